// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder for the serial sequence detector. It accepts a word
// through a valid/ready handshake and shifts it out one bit per clock, with no idle gap between words.
module serial_bit_feeder #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b0,
  parameter bit          IDLE_BIT  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt, sreg_sh;
  logic             sout_nxt, sout_valid_nxt;
  logic             last_bit, accept, first_bit, next_bit;

  // The last-bit cycle doubles as the reload window, so words can run back to back.
  assign last_bit  = (state == SHIFT) && (cnt == LAST);
  assign din_ready = !rst && ((state == IDLE) || last_bit);
  assign accept    = din_valid && din_ready;
  assign word_done = last_bit;
  assign busy      = (state == SHIFT);

  assign first_bit = LSB_FIRST ? din[0] : din[WIDTH-1];
  assign sreg_sh   = LSB_FIRST ? (sreg >> 1) : (sreg << 1);
  assign next_bit  = LSB_FIRST ? sreg_sh[0] : sreg_sh[WIDTH-1];

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sreg       <= '0;
      sout       <= IDLE_BIT;
      sout_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sreg       <= sreg_nxt;
      sout       <= sout_nxt;
      sout_valid <= sout_valid_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    sreg_nxt       = sreg;
    sout_nxt       = sout;
    sout_valid_nxt = sout_valid;
    if (accept) begin
      state_nxt      = SHIFT;
      cnt_nxt        = '0;
      sreg_nxt       = din;
      sout_nxt       = first_bit;
      sout_valid_nxt = 1'b1;
    end else begin
      case (state)
        SHIFT: begin
          if (last_bit) begin
            state_nxt      = IDLE;
            sout_nxt       = IDLE_BIT;
            sout_valid_nxt = 1'b0;
          end else begin
            cnt_nxt  = cnt + CW'(1);
            sreg_nxt = sreg_sh;
            sout_nxt = next_bit;
          end
        end
        IDLE: begin
          sout_nxt       = IDLE_BIT;
          sout_valid_nxt = 1'b0;
        end
        default: begin
          state_nxt      = IDLE;
          cnt_nxt        = '0;
          sout_nxt       = IDLE_BIT;
          sout_valid_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Scoreboard bench for serial_bit_feeder: covers the 8-bit MSB-first, 8-bit LSB-first and 1-bit configurations.
module tb_serial_bit_feeder;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] din_a, din_b;
  logic [0:0] din_c;
  logic dv_a, dv_b, dv_c;
  logic rdy_a, rdy_b, rdy_c;
  logic so_a, so_b, so_c;
  logic sv_a, sv_b, sv_c;
  logic wd_a, wd_b, wd_c;
  logic bz_a, bz_b, bz_c;

  serial_bit_feeder #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_msb (
    .clk(clk), .rst(rst), .din(din_a), .din_valid(dv_a), .din_ready(rdy_a),
    .sout(so_a), .sout_valid(sv_a), .word_done(wd_a), .busy(bz_a));

  serial_bit_feeder #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .din(din_b), .din_valid(dv_b), .din_ready(rdy_b),
    .sout(so_b), .sout_valid(sv_b), .word_done(wd_b), .busy(bz_b));

  serial_bit_feeder #(.WIDTH(1), .LSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_w1 (
    .clk(clk), .rst(rst), .din(din_c), .din_valid(dv_c), .din_ready(rdy_c),
    .sout(so_c), .sout_valid(sv_c), .word_done(wd_c), .busy(bz_c));

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Expected bit stream of one word in shift order
  task automatic push(input int k, input int w, input bit lsb, input logic [31:0] word);
    exp_t e;
    for (int i = 0; i < w; i++) begin
      e.b    = word[lsb ? i : (w - 1 - i)];
      e.last = (i == w - 1);
      case (k)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endtask

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic mon(input int k, input logic sv, input logic [2:0] obs);
    exp_t e;
    if (sv) begin
      if (qsize(k) == 0) begin
        check($sformatf("extra_bit%0d", k), 32'(1), 32'(0));
      end else begin
        case (k)
          0:       e = q0.pop_front();
          1:       e = q1.pop_front();
          default: e = q2.pop_front();
        endcase
        check($sformatf("bit%0d{sout,done,busy}", k), 32'(obs), 32'({e.b, e.last, 1'b1}));
      end
    end else begin
      check($sformatf("idle%0d{sout,done,busy}", k), 32'(obs), 32'(3'b100));
    end
  endtask

  always @(negedge clk) begin
    mon(0, sv_a, {so_a, wd_a, bz_a});
    mon(1, sv_b, {so_b, wd_b, bz_b});
    mon(2, sv_c, {so_c, wd_c, bz_c});
  end

  task automatic watch(input int k, input int n, output int vc, output int wc);
    vc = 0;
    wc = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      case (k)
        0:       begin vc += int'(sv_a); wc += int'(wd_a); end
        1:       begin vc += int'(sv_b); wc += int'(wd_b); end
        default: begin vc += int'(sv_c); wc += int'(wd_c); end
      endcase
      @(posedge clk);
    end
  endtask

  task automatic drain(input int k);
    for (int i = 0; i < 40 && qsize(k) != 0; i++) @(posedge clk);
    @(negedge clk);
    check($sformatf("drain%0d", k), 32'(qsize(k)), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v1, w1, v2, w2, v3, w3;
    rst = 1'b1;
    din_a = '0; din_b = '0; din_c = '0;
    dv_a = 1'b0; dv_b = 1'b0; dv_c = 1'b0;

    @(negedge clk);
    check("rst{sout,valid,busy,done}", 32'({so_a, sv_a, bz_a, wd_a}), 32'(4'b1000));
    check("rst_ready_a", 32'(rdy_a), 32'(0));
    check("rst_ready_c", 32'(rdy_c), 32'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(rdy_a), 32'(1));

    // Single word 0110_0000, MSB first
    @(posedge clk); #1 din_a = 8'h60; dv_a = 1'b1; push(0, 8, 1'b0, 32'h60);
    @(posedge clk); #1 dv_a = 1'b0;
    watch(0, 8, v1, w1);
    check("single_valid_cycles", 32'(v1), 32'(8));
    check("single_done_pulses", 32'(w1), 32'(1));
    @(negedge clk);
    check("single_after{sout,valid,ready}", 32'({so_a, sv_a, rdy_a}), 32'(3'b101));

    // Back-to-back A5 then 3C with valid held
    @(posedge clk); #1 din_a = 8'hA5; dv_a = 1'b1; push(0, 8, 1'b0, 32'hA5);
    @(posedge clk);
    #1 watch(0, 7, v1, w1);
    #1 din_a = 8'h3C; push(0, 8, 1'b0, 32'h3C);
    watch(0, 1, v2, w2);
    #1 dv_a = 1'b0;
    watch(0, 8, v3, w3);
    check("b2b_valid_cycles", 32'(v1 + v2 + v3), 32'(16));
    check("b2b_done_cycle8", 32'(w2), 32'(1));
    check("b2b_done_total", 32'(w1 + w2 + w3), 32'(2));
    drain(0);

    // Busy blocking: din churns during the word, next word loads at cycle 8
    @(posedge clk); #1 din_a = 8'hC3; dv_a = 1'b1; push(0, 8, 1'b0, 32'hC3);
    @(posedge clk);
    for (int c = 1; c <= 7; c++) begin
      #1 din_a = 8'($urandom);
      @(negedge clk);
      check($sformatf("busy_ready_c%0d", c), 32'(rdy_a), 32'(0));
      @(posedge clk);
    end
    #1 din_a = 8'h5A; push(0, 8, 1'b0, 32'h5A);
    @(negedge clk);
    check("busy_ready_c8", 32'(rdy_a), 32'(1));
    @(posedge clk); #1 dv_a = 1'b0;
    drain(0);

    // Asynchronous reset in cycle 4 of 8'hFF
    @(posedge clk); #1 din_a = 8'hFF; dv_a = 1'b1; push(0, 8, 1'b0, 32'hFF);
    @(posedge clk); #1 dv_a = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    q0.delete();
    #1;
    check("async_rst{sout,valid,busy,done,ready}", 32'({so_a, sv_a, bz_a, wd_a, rdy_a}), 32'(5'b10000));
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 din_a = 8'h0F; dv_a = 1'b1; push(0, 8, 1'b0, 32'h0F);
    @(posedge clk); #1 dv_a = 1'b0;
    drain(0);

    // LSB first, 8'h06
    @(posedge clk); #1 din_b = 8'h06; dv_b = 1'b1; push(1, 8, 1'b1, 32'h06);
    @(posedge clk); #1 dv_b = 1'b0;
    watch(1, 8, v1, w1);
    check("lsb_valid_cycles", 32'(v1), 32'(8));
    check("lsb_done_pulses", 32'(w1), 32'(1));
    drain(1);

    // WIDTH=1: one accept per cycle, 0,1,0,1
    @(posedge clk); #1 din_c = 1'b0; dv_c = 1'b1; push(2, 1, 1'b0, 32'h0);
    v1 = 0; w1 = 0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      if (i < 4) begin
        din_c = 1'(i);
        push(2, 1, 1'b0, 32'(i & 1));
      end else begin
        dv_c = 1'b0;
      end
      @(negedge clk);
      v1 += int'(sv_c);
      w1 += int'(wd_c);
      check($sformatf("w1_ready_c%0d", i), 32'(rdy_c), 32'(1));
    end
    check("w1_valid_cycles", 32'(v1), 32'(4));
    check("w1_done_cycles", 32'(w1), 32'(4));
    drain(2);
    check("w1_after_valid", 32'(sv_c), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
